id_operand_fetch: RTL and testbench
===================================

Name: id_operand_fetch

Overview:
- Decode-stage operand reader: the read-side counterpart to the register file's write port.
- Takes the instruction held in IF/ID, drives the two register-file read addresses and takes the returned data.
- Applies write-back bypass and $0 forcing, detects load-use hazards, and captures operands plus decoded fields into the ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage, alongside the register file.

Parameters:
- DATA_W, 32, operand and register data width.
- REG_ADDR_W, 5, register specifier width (32 registers).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction from IF/ID.
- instr_valid  input  1  instr_in holds a real instruction (0 = bubble).
- stall_in  input  1  downstream backpressure; hold the ID/EX register.
- flush  input  1  kill the instruction being captured (branch/jump redirect).
- rf_reg1  output  REG_ADDR_W  register-file read address 1 = instr_in[25:21] (rs), combinational.
- rf_reg2  output  REG_ADDR_W  register-file read address 2 = instr_in[20:16] (rt), combinational.
- rf_data1  input  DATA_W  register-file read data for rf_reg1.
- rf_data2  input  DATA_W  register-file read data for rf_reg2.
- wb_reg_write  input  1  write-back enable (same signal as the register-file write enable).
- wb_w_reg  input  REG_ADDR_W  write-back destination register.
- wb_data  input  DATA_W  write-back data.
- stall_out  output  1  hold PC and IF/ID; combinational.
- ex_valid  output  1  ID/EX holds a valid instruction.
- ex_opcode  output  6  captured instr[31:26].
- ex_funct  output  6  captured instr[5:0].
- ex_rs, ex_rt, ex_rd  output  REG_ADDR_W each  captured instr[25:21], [20:16], [15:11].
- ex_rs_data, ex_rt_data  output  DATA_W each  captured operands.
- ex_imm  output  32  captured sign-extended instr[15:0].

Behaviour:
- Operand select, combinational:
  - Register specifier 0 always yields 0, regardless of rf_data or bypass.
  - Otherwise, when bypass matches (see Optional Feature), use wb_data.
  - Otherwise use rf_data1 / rf_data2.
- uses_rt = 1 when opcode is 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- hazard = ex_valid & (ex_opcode==0x23, lw) & ex_rt!=0 & instr_valid & (ex_rt==rs | (uses_rt & ex_rt==rt)).
- stall_out = hazard | stall_in.
- Posedge update, in priority order:
  1. reset: all ex_* outputs go to 0, including ex_valid.
  2. flush: ex_valid<=0; other fields are don't-care, and the bench must not check them.
  3. stall_in: every ex_* register holds its value.
  4. hazard: insert a bubble, ex_valid<=0; IF/ID is held by stall_out, so the same instruction is re-evaluated next cycle.
  5. Otherwise capture all fields; ex_valid<=instr_valid.
- Latency: operands appear on ex_* exactly one clock after the instruction is presented un-stalled.
- A load-use hazard costs exactly one bubble. The next cycle the load has moved on from ID/EX, and its later write-back is covered by the bypass.
- flush together with stall_in: flush wins and ex_valid goes to 0.
- Reset mid-stall: cleared on the same edge; stall_out then follows its inputs combinationally.
- No internal state beyond the ID/EX register.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when wb_reg_write & wb_w_reg==specifier & specifier!=0, the operand takes wb_data in the same cycle. This gives same-cycle write-then-read coherence even though the register file writes on negedge and only re-reads when its addresses change.
- Undefined: operands come from rf_data only (with $0 forcing). Same-cycle WB-to-ID dependencies are then unresolved; this build is for isolating register-file behaviour only.

Test Plan:
- Reset, then add $3,$1,$2 with rf_data1=5, rf_data2=7, no WB -> next cycle ex_valid=1, ex_rs_data=5, ex_rt_data=7, ex_rd=3.
- lw $4,8($1) followed by add $5,$4,$2 -> stall_out=1 for one cycle, one bubble (ex_valid=0), then add captured with ex_valid=1.
- WB_BYPASS_EN defined; wb_reg_write=1, wb_w_reg=2, wb_data=0xDEAD while ID reads rs=2 with rf_data1=0x1111 -> ex_rs_data=0xDEAD. Same case without the macro -> 0x1111.
- Instruction reads $0 with rf_data1=0xFFFFFFFF and a WB to $0 in the same cycle -> ex_rs_data=0.
- stall_in=1 for 3 cycles, with a different instr_in each cycle -> ex_* unchanged throughout; flush=1 together with stall_in -> ex_valid=0 next edge.
- addi with imm 0x8000 -> ex_imm=0xFFFF8000. lw $0 followed by a use of $0 -> no stall.

Source files
------------

// File: rtl/id_operand_fetch.sv
// Decode-stage operand reader: register-file read addressing, $0 forcing, load-use
// hazard detection and ID/EX capture. Define WB_BYPASS_EN to enable write-back bypass.
module id_operand_fetch #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_in,
    input  logic                  instr_valid,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] rf_reg1,
    output logic [REG_ADDR_W-1:0] rf_reg2,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [DATA_W-1:0]     rf_data2,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_w_reg,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [5:0]            ex_opcode,
    output logic [5:0]            ex_funct,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [31:0]           ex_imm
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     rs_data, rt_data;
    logic                  uses_rt, hazard;

    assign opcode  = instr_in[31:26];
    assign rs      = instr_in[21 +: REG_ADDR_W];
    assign rt      = instr_in[16 +: REG_ADDR_W];
    assign rd      = instr_in[11 +: REG_ADDR_W];
    assign rf_reg1 = rs;
    assign rf_reg2 = rt;

`ifndef WB_BYPASS_EN
    // Write-back port is only consumed by the bypass build.
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_w_reg, wb_data};
`endif

    always_comb begin
        rs_data = rf_data1;
        rt_data = rf_data2;
`ifdef WB_BYPASS_EN
        if (wb_reg_write && wb_w_reg == rs) rs_data = wb_data;
        if (wb_reg_write && wb_w_reg == rt) rt_data = wb_data;
`endif
        // $0 is forced last so neither the file nor a bypass can override it.
        if (rs == '0) rs_data = '0;
        if (rt == '0) rt_data = '0;
    end

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

    assign hazard = ex_valid && (ex_opcode == OP_LW) && (ex_rt != '0) && instr_valid &&
                    ((ex_rt == rs) || (uses_rt && ex_rt == rt));

    assign stall_out = hazard || stall_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_opcode  <= '0;
            ex_funct   <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (stall_in) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            // IF/ID is held by stall_out, so this instruction retries next cycle.
            ex_valid <= 1'b0;
        end else begin
            ex_valid   <= instr_valid;
            ex_opcode  <= opcode;
            ex_funct   <= instr_in[5:0];
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= {{16{instr_in[15]}}, instr_in[15:0]};
        end
    end
endmodule

// File: tb/tb_id_operand_fetch.sv
// Self-checking bench for id_operand_fetch: directed scenarios plus a randomized run
// against a rule-level reference model.
module tb_id_operand_fetch;
    logic        clk = 1'b0;
    logic        reset, instr_valid, stall_in, flush, wb_reg_write;
    logic [31:0] instr_in, rf_data1, rf_data2, wb_data;
    logic [4:0]  wb_w_reg, rf_reg1, rf_reg2;
    logic        stall_out, ex_valid;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_operand_fetch dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .stall_in(stall_in), .flush(flush), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
        .wb_w_reg(wb_w_reg), .wb_data(wb_data), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Value an operand should take under the architectural rules.
    function automatic logic [31:0] ref_opnd(input logic [4:0] spec, input logic [31:0] rf,
                                             input logic wbw, input logic [4:0] wbr,
                                             input logic [31:0] wbd);
        if (spec == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wbw && wbr == spec) return wbd;
`endif
        return rf;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, st, fl,
                         input logic [31:0] d1, d2, input logic wbw,
                         input logic [4:0] wbr, input logic [31:0] wbd);
        instr_in = ins; instr_valid = v; stall_in = st; flush = fl;
        rf_data1 = d1; rf_data2 = d2; wb_reg_write = wbw; wb_w_reg = wbr; wb_data = wbd;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        drive(rtype(5'd7, 5'd6, 5'd5, 6'h20), 1'b1, 1'b0, 1'b0, 32'hAAAA, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        tick();
        // reset while stalled must still clear everything on this edge
        stall_in = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({ex_valid, ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm} !== '0) begin
            n_fail++;
            $display("FAIL reset_clear got valid=%0b rs_data=%h imm=%h want all zero", ex_valid, ex_rs_data, ex_imm);
        end
        #1;
        n_tests++;
        if (stall_out !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follow got %0b want 1", stall_out); end
        stall_in = 1'b0; #1;
        n_tests++;
        if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall_drop got %0b want 0", stall_out); end
    endtask

    task automatic test_basic;
        do_reset();
        drive(rtype(5'd3, 5'd1, 5'd2, 6'h20), 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++;
        if ({rf_reg1, rf_reg2} !== {5'd1, 5'd2}) begin
            n_fail++; $display("FAIL basic_addr got %0d,%0d want 1,2", rf_reg1, rf_reg2);
        end
        tick();
        n_tests++;
        if ({ex_valid, ex_rs_data, ex_rt_data, ex_rd, ex_funct} !== {1'b1, 32'd5, 32'd7, 5'd3, 6'h20}) begin
            n_fail++;
            $display("FAIL basic_add got v=%0b rs=%0d rt=%0d rd=%0d fn=%h want 1 5 7 3 20",
                     ex_valid, ex_rs_data, ex_rt_data, ex_rd, ex_funct);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        drive(itype(6'h23, 5'd1, 5'd4, 16'd8), 1'b1, 1'b0, 1'b0, 32'd100, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        drive(rtype(5'd5, 5'd4, 5'd2, 6'h20), 1'b1, 1'b0, 1'b0, 32'd11, 32'd22, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++;
        if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0b want 1", stall_out); end
        tick();
        n_tests++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0b want 0", ex_valid); end
        n_tests++;
        if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_one_bubble got %0b want 0", stall_out); end
        tick();
        n_tests++;
        if ({ex_valid, ex_rs, ex_rd, ex_rs_data} !== {1'b1, 5'd4, 5'd5, 32'd11}) begin
            n_fail++;
            $display("FAIL lu_capture got v=%0b rs=%0d rd=%0d d=%0d want 1 4 5 11", ex_valid, ex_rs, ex_rd, ex_rs_data);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] want;
`ifdef WB_BYPASS_EN
        want = 32'hDEAD;
`else
        want = 32'h1111;
`endif
        do_reset();
        drive(rtype(5'd9, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0, 32'h1111, 32'h3333, 1'b1, 5'd2, 32'hDEAD);
        tick();
        n_tests++;
        if ({ex_rs_data, ex_rt_data} !== {want, 32'h3333}) begin
            n_fail++; $display("FAIL bypass got rs=%h rt=%h want %h 3333", ex_rs_data, ex_rt_data, want);
        end
        drive(rtype(5'd9, 5'd0, 5'd0, 6'h20), 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hBEEF);
        tick();
        n_tests++;
        if ({ex_rs_data, ex_rt_data} !== 64'd0) begin
            n_fail++; $display("FAIL zero_force got rs=%h rt=%h want 0 0", ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_stall_flush;
        do_reset();
        drive(itype(6'h08, 5'd6, 5'd7, 16'h1234), 1'b1, 1'b0, 1'b0, 32'h66, 32'h77, 1'b0, 5'd0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b0, 5'd0, 32'd0);
            tick();
            n_tests++;
            if ({ex_valid, ex_opcode, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm} !==
                {1'b1, 6'h08, 5'd6, 5'd7, 32'h66, 32'h77, 32'h00001234}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got v=%0b op=%h rs_d=%h imm=%h want 1 08 66 00001234",
                         i, ex_valid, ex_opcode, ex_rs_data, ex_imm);
            end
        end
        flush = 1'b1;
        tick();
        n_tests++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0b want 0", ex_valid); end
    endtask

    task automatic test_imm_lw_zero;
        do_reset();
        drive(itype(6'h08, 5'd1, 5'd2, 16'h8000), 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
        tick();
        n_tests++;
        if (ex_imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL imm_sext got %h want FFFF8000", ex_imm); end
        drive(itype(6'h23, 5'd1, 5'd0, 16'd4), 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
        tick();
        drive(rtype(5'd5, 5'd0, 5'd0, 6'h20), 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lw_zero_nostall got %0b want 0", stall_out); end
        // a bubble in ID never stalls, even behind a matching load
        drive(itype(6'h23, 5'd1, 5'd3, 16'd0), 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
        tick();
        drive(rtype(5'd5, 5'd3, 5'd3, 6'h20), 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin n_fail++; $display("FAIL bubble_nostall got %0b want 0", stall_out); end
    endtask

    task automatic test_random;
        logic [5:0]  ops [7] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08, 6'h0D};
        logic        m_valid = 1'b0, m_known = 1'b1, exp_stall, hz, ut;
        logic [5:0]  m_op = '0, m_fn = '0, op;
        logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0, rs, rt, rd;
        logic [31:0] m_rsd = '0, m_rtd = '0, m_imm = '0, ins;
        logic        held = 1'b0;
        do_reset();
        ins = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                op = ops[$urandom_range(0, 6)];
                rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
                ins = {op, rs, rt, rd, 11'($urandom)};
            end
            drive(ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                  $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            ut = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
            hz = m_valid && m_op == 6'h23 && m_rt != 0 && instr_valid && (m_rt == rs || (ut && m_rt == rt));
            exp_stall = hz || stall_in;
            #1;
            n_tests++;
            if ({stall_out, rf_reg1, rf_reg2} !== {exp_stall, rs, rt}) begin
                n_fail++;
                $display("FAIL rand_comb[%0d] got st=%0b a=%0d,%0d want %0b %0d,%0d",
                         c, stall_out, rf_reg1, rf_reg2, exp_stall, rs, rt);
            end
            if (flush) begin
                m_valid = 1'b0; m_known = 1'b0;
            end else if (stall_in) begin
            end else if (hz) begin
                m_valid = 1'b0;
            end else begin
                m_valid = instr_valid; m_known = 1'b1;
                m_op = op; m_fn = ins[5:0]; m_rs = rs; m_rt = rt; m_rd = rd;
                m_rsd = ref_opnd(rs, rf_data1, wb_reg_write, wb_w_reg, wb_data);
                m_rtd = ref_opnd(rt, rf_data2, wb_reg_write, wb_w_reg, wb_data);
                m_imm = {{16{ins[15]}}, ins[15:0]};
            end
            held = exp_stall && !flush;
            tick();
            n_tests++;
            if (ex_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_valid[%0d] got %0b want %0b", c, ex_valid, m_valid);
            end
            if (m_known) begin
                n_tests++;
                if ({ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm} !==
                    {m_op, m_fn, m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm}) begin
                    n_fail++;
                    $display("FAIL rand_fields[%0d] got op=%h rs=%0d rt=%0d rsd=%h rtd=%h imm=%h want %h %0d %0d %h %h %h",
                             c, ex_opcode, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm,
                             m_op, m_rs, m_rt, m_rsd, m_rtd, m_imm);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_basic();
        test_load_use();
        test_bypass();
        test_stall_flush();
        test_imm_lw_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
